// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared op codes, field constants and per-op control lookup for RV32I encode/decode
package rv32i_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL,
    OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_JALR,
    OP_SLLI, OP_SRLI, OP_SW, OP_BEQ, OP_BNE,
    OP_LUI, OP_AUIPC, OP_JAL
  } op_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;
  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_S     = 7'h23;
  localparam logic [6:0] OPC_B     = 7'h63;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_SRL = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    imm_src_e   src;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
  } ctrl_t;
  function automatic ctrl_t op_ctrl(input logic [4:0] op);
    ctrl_t c;
    c = '{IMM_NONE, OPC_R, F3_ADD, F7_BASE, 1'b0};
    case (op)
      OP_ADD:   c = '{IMM_NONE, OPC_R, F3_ADD, F7_BASE, 1'b1};
      OP_SUB:   c = '{IMM_NONE, OPC_R, F3_ADD, F7_SUB, 1'b1};
      OP_AND:   c = '{IMM_NONE, OPC_R, F3_AND, F7_BASE, 1'b1};
      OP_OR:    c = '{IMM_NONE, OPC_R, F3_OR, F7_BASE, 1'b1};
      OP_SLL:   c = '{IMM_NONE, OPC_R, F3_SLL, F7_BASE, 1'b1};
      OP_SRL:   c = '{IMM_NONE, OPC_R, F3_SRL, F7_BASE, 1'b1};
      OP_ADDI:  c = '{IMM_I, OPC_I, F3_ADD, F7_BASE, 1'b1};
      OP_ANDI:  c = '{IMM_I, OPC_I, F3_AND, F7_BASE, 1'b1};
      OP_ORI:   c = '{IMM_I, OPC_I, F3_OR, F7_BASE, 1'b1};
      OP_LW:    c = '{IMM_I, OPC_LOAD, F3_LW, F7_BASE, 1'b1};
      OP_JALR:  c = '{IMM_I, OPC_JALR, F3_ADD, F7_BASE, 1'b1};
      OP_SLLI:  c = '{IMM_SH, OPC_I, F3_SLL, F7_BASE, 1'b1};
      OP_SRLI:  c = '{IMM_SH, OPC_I, F3_SRL, F7_BASE, 1'b1};
      OP_SW:    c = '{IMM_S, OPC_S, F3_SW, F7_BASE, 1'b1};
      OP_BEQ:   c = '{IMM_B, OPC_B, F3_BEQ, F7_BASE, 1'b1};
      OP_BNE:   c = '{IMM_B, OPC_B, F3_BNE, F7_BASE, 1'b1};
      OP_LUI:   c = '{IMM_U, OPC_LUI, F3_ADD, F7_BASE, 1'b1};
      OP_AUIPC: c = '{IMM_U, OPC_AUIPC, F3_ADD, F7_BASE, 1'b1};
      OP_JAL:   c = '{IMM_J, OPC_JAL, F3_ADD, F7_BASE, 1'b1};
      default:  c = '{IMM_NONE, OPC_R, F3_ADD, F7_BASE, 1'b0};
    endcase
    return c;
  endfunction
endpackage

// File: rtl/rv32i_encode_comb.sv
// rv32i_encode_comb: combinational descriptor to RV32I word with range/legality check
module rv32i_encode_comb
  import rv32i_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  ctrl_t c;
  logic [31:0] raw;
  logic ok;
  always_comb begin
    c = op_ctrl(op);
    raw = '0;
    ok = 1'b1;
    case (c.src)
      IMM_NONE: raw = {c.f7, rs2, rs1, c.f3, rd, c.opc};
      IMM_I: begin
        raw = {imm[11:0], rs1, c.f3, rd, c.opc};
        ok = &imm[31:11] || ~|imm[31:11];
      end
      IMM_SH: begin
        raw = {c.f7, imm[4:0], rs1, c.f3, rd, c.opc};
        ok = ~|imm[31:5];
      end
      IMM_S: begin
        raw = {imm[11:5], rs2, rs1, c.f3, imm[4:0], c.opc};
        ok = &imm[31:11] || ~|imm[31:11];
      end
      IMM_B: begin
        raw = {imm[12], imm[10:5], rs2, rs1, c.f3, imm[4:1], imm[11], c.opc};
        ok = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
      end
      IMM_U: begin
        raw = {imm[31:12], rd, c.opc};
        ok = ~|imm[11:0];
      end
      IMM_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, c.opc};
        ok = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
      end
      default: ok = 1'b0;
    endcase
    illegal = !c.legal || !ok;
    word = illegal ? NOP : raw;
  end
endmodule

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: streams encoded RV32I words into IMEM through a single-entry output register
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);
  state_e state, state_n;
  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0] remaining;
  logic [31:0] word;
  logic illegal, drained, accept;
  rv32i_encode_comb u_enc (
    .op(in_op),
    .rd(in_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .imm(in_imm),
    .word(word),
    .illegal(illegal)
  );
  assign drained = !imem_we || imem_ready;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? (count == '0 ? DRAIN : LOAD) : IDLE)
            : state == LOAD ? (accept && remaining == CNT_W'(1) ? DRAIN : LOAD)
            : (drained ? IDLE : DRAIN);
  end
  always_comb begin
    busy = state != IDLE;
    in_ready = state == LOAD && drained;
    done = state == DRAIN && drained;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      err <= 1'b0;
      err_addr <= '0;
      next_addr <= '0;
      remaining <= '0;
    end else begin
      if (state == IDLE && start) begin
        next_addr <= base_addr & ~ADDR_W'(3);
        remaining <= count;
        err <= 1'b0;
        err_addr <= '0;
      end
      if (accept) begin
        imem_we <= 1'b1;
        imem_addr <= next_addr;
        imem_wdata <= word;
        next_addr <= next_addr + ADDR_W'(4);
        remaining <= remaining - CNT_W'(1);
        if (illegal && !err) begin
          err <= 1'b1;
          err_addr <= next_addr;
        end
      end else if (imem_ready) begin
        imem_we <= 1'b0;
      end
    end
  end
endmodule
